csr_file: RTL
=============

# csr_file

Machine-mode CSR register file for the RV32 core: the write-side end of the EXE stage's CSR writeback interface and the read source for DEC. It holds the trap CSRs, the 64-bit cycle and instret counters, and the trap/mret state updates. It drives mtvec/mepc/MIE to the fetch and flush logic.

## Interface
- XLEN, 32, data width; only 32 is supported.
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- csr_wbk_v_q_i  in  1  CSR write valid from EXE writeback
- csr_adr_q_i  in  12  CSR write address
- csr_data_q_i  in  XLEN  CSR write data (final value, already computed by EXE)
- csr_rd_adr_i  in  12  DEC read address
- csr_rd_data_o  out  XLEN  read data, combinational
- csr_rd_illegal_o  out  1  read address not implemented
- exception_i  in  1  trap taken this cycle
- cause_i  in  XLEN  mcause value for the trap
- mtval_i  in  XLEN  mtval value for the trap
- epc_i  in  XLEN  PC of the trapping instruction
- mret_i  in  1  mret retiring this cycle
- instret_i  in  1  one instruction retired this cycle
- mtvec_q_o  out  XLEN  registered mtvec (trap target)
- mepc_q_o  out  XLEN  registered mepc (mret target)
- mstatus_mie_q_o  out  1  registered mstatus.MIE

## Operation
Implemented CSRs, with reset values:
- mstatus 0x300: MIE[3], MPIE[7] and MPP[12:11] are writable; all other bits read 0. Reset 0x0000_1800.
- misa 0x301: read-only 0x4000_0100.
- mtvec 0x305: bits[1:0] are forced to 0 (direct mode). Reset 0.
- mscratch 0x340: reset 0.
- mepc 0x341: bits[1:0] are forced to 0. Reset 0.
- mcause 0x342: reset 0.
- mtval 0x343: reset 0.
- mcycle 0xB00 / mcycleh 0xB80: one 64-bit counter. Reset 0.
- minstret 0xB02 / minstreth 0xB82: one 64-bit counter. Reset 0.
- mhartid 0xF14: read-only 0.

Write rules:
- Writes to read-only or unimplemented addresses are dropped with no side effect.
- Read-only addresses are not flagged as illegal. Only unimplemented addresses raise csr_rd_illegal_o.
- Unimplemented read addresses return 0 with csr_rd_illegal_o=1.

Read path:
- csr_rd_data_o is combinational.
- Internal bypass: if csr_wbk_v_q_i=1 and csr_adr_q_i equals csr_rd_adr_i and the address is writable, return the masked csr_data_q_i.
- Otherwise return the current register value.
- No bypass of trap, mret or counter-increment updates.

Same-cycle update priority, per field:
1. The CSR write is applied first.
2. A trap (exception_i) then overrides its fields:
   - mepc <= epc_i & ~3
   - mcause <= cause_i
   - mtval <= mtval_i
   - MPIE <= MIE
   - MIE <= 0
   - MPP <= 2'b11
3. exception_i and mret_i both high: the trap wins and mret is ignored.
4. mret (no exception): MIE <= MPIE, MPIE <= 1, MPP <= 2'b00.

Example of the split: a write to mscratch in a trap cycle commits. A write to mcause in a trap cycle is lost.

Counters:
- mcycle increments by 1 every cycle out of reset.
- minstret increments by 1 when instret_i=1.
- Both counters wrap from 2^64-1 to 0. Carry propagates from the low word into the high word in the same cycle.
- Write to either half: that half loads the write data and the counter does not increment that cycle. The other half holds its value.

## Timing
- All state is updated on the rising edge of clk.
- A write or trap in cycle N is visible on csr_rd_data_o (without bypass) and on the *_q_o outputs in cycle N+1.
- mtvec_q_o and mepc_q_o are combinational views of their registers; no extra pipeline stage.
- Reset asserted mid-operation clears every register immediately to its reset value. Outputs during and after reset:
  - mtvec_q_o = 0
  - mepc_q_o = 0
  - mstatus_mie_q_o = 0
  - csr_rd_data_o reflects the reset values
- The first increment of mcycle happens on the first rising edge after reset_n deasserts.

## Test plan
- Reset, then read 0x300, 0x301, 0xF14, 0x7C0 -> 0x1800 / 0x4000_0100 / 0 / 0 with illegal=1. mcycle reads 5 after 5 edges.
- Write mtvec=0x8000_0103; in the same cycle read 0x305 -> bypass gives 0x8000_0100; next cycle mtvec_q_o=0x8000_0100.
- Write mstatus=0x8, then exception_i with epc=0x1006, cause=2, mtval=0xDEAD. Next cycle: mepc=0x1004, mcause=2, mtval=0xDEAD, mstatus=0x1880, MIE=0. Then mret_i -> mstatus=0x0088, MIE=1.
- In one cycle: exception_i, a write of mcause=7 and a write of mscratch=0x55 -> mcause=cause_i and mscratch=0x55. Then exception_i and mret_i together -> trap update only.
- Write mcycle=0xFFFF_FFFF -> next cycle reads 0xFFFF_FFFF (no increment that cycle). Following cycle: mcycle=0 and mcycleh=1.
- Write mcycleh=0xFFFF_FFFF and mcycle=0xFFFF_FFFE, then run 2 cycles -> wraps to 0/0. instret_i pulsed 3 times -> minstret=3.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap CSRs, 64-bit cycle/instret counters, trap/mret state updates.
// Only XLEN = 32 is supported; the counters are split into 32-bit halves.
module csr_file #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            csr_wbk_v_q_i,
  input  logic [11:0]     csr_adr_q_i,
  input  logic [XLEN-1:0] csr_data_q_i,
  input  logic [11:0]     csr_rd_adr_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_rd_illegal_o,
  input  logic            exception_i,
  input  logic [XLEN-1:0] cause_i,
  input  logic [XLEN-1:0] mtval_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            mret_i,
  input  logic            instret_i,
  output logic [XLEN-1:0] mtvec_q_o,
  output logic [XLEN-1:0] mepc_q_o,
  output logic            mstatus_mie_q_o
);

  localparam logic [11:0] AdrMstatus   = 12'h300;
  localparam logic [11:0] AdrMisa      = 12'h301;
  localparam logic [11:0] AdrMtvec     = 12'h305;
  localparam logic [11:0] AdrMscratch  = 12'h340;
  localparam logic [11:0] AdrMepc      = 12'h341;
  localparam logic [11:0] AdrMcause    = 12'h342;
  localparam logic [11:0] AdrMtval     = 12'h343;
  localparam logic [11:0] AdrMcycle    = 12'hB00;
  localparam logic [11:0] AdrMinstret  = 12'hB02;
  localparam logic [11:0] AdrMcycleh   = 12'hB80;
  localparam logic [11:0] AdrMinstreth = 12'hB82;
  localparam logic [11:0] AdrMhartid   = 12'hF14;

  localparam logic [XLEN-1:0] MisaVal      = 32'h4000_0100;
  localparam logic [XLEN-1:0] MstatusMask  = 32'h0000_1888;
  localparam logic [XLEN-1:0] AlignMask    = 32'hFFFF_FFFC;

  // State
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [1:0]      mpp_q, mpp_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  // Write-side address decode (independent of valid, used for bypass qualification)
  logic sel_mstatus, sel_mtvec, sel_mscratch, sel_mepc, sel_mcause, sel_mtval;
  logic sel_mcycle, sel_mcycleh, sel_minstret, sel_minstreth;
  logic wr_writable;
  logic [XLEN-1:0] wr_data_m;

  always_comb begin
    sel_mstatus   = 1'b0;
    sel_mtvec     = 1'b0;
    sel_mscratch  = 1'b0;
    sel_mepc      = 1'b0;
    sel_mcause    = 1'b0;
    sel_mtval     = 1'b0;
    sel_mcycle    = 1'b0;
    sel_mcycleh   = 1'b0;
    sel_minstret  = 1'b0;
    sel_minstreth = 1'b0;
    wr_data_m     = csr_data_q_i;
    case (csr_adr_q_i)
      AdrMstatus: begin
        sel_mstatus = 1'b1;
        wr_data_m   = csr_data_q_i & MstatusMask;
      end
      AdrMtvec: begin
        sel_mtvec = 1'b1;
        wr_data_m = csr_data_q_i & AlignMask;
      end
      AdrMscratch:  sel_mscratch = 1'b1;
      AdrMepc: begin
        sel_mepc  = 1'b1;
        wr_data_m = csr_data_q_i & AlignMask;
      end
      AdrMcause:    sel_mcause    = 1'b1;
      AdrMtval:     sel_mtval     = 1'b1;
      AdrMcycle:    sel_mcycle    = 1'b1;
      AdrMcycleh:   sel_mcycleh   = 1'b1;
      AdrMinstret:  sel_minstret  = 1'b1;
      AdrMinstreth: sel_minstreth = 1'b1;
      default: ;
    endcase
    wr_writable = sel_mstatus | sel_mtvec | sel_mscratch | sel_mepc | sel_mcause | sel_mtval |
                  sel_mcycle | sel_mcycleh | sel_minstret | sel_minstreth;
  end

  // Read path: register view, then same-address write bypass
  logic [XLEN-1:0] reg_rd_data;
  logic            rd_unimpl;
  logic            bypass;

  always_comb begin
    reg_rd_data = '0;
    rd_unimpl   = 1'b0;
    case (csr_rd_adr_i)
      AdrMstatus:   reg_rd_data = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      AdrMisa:      reg_rd_data = MisaVal;
      AdrMtvec:     reg_rd_data = mtvec_q;
      AdrMscratch:  reg_rd_data = mscratch_q;
      AdrMepc:      reg_rd_data = mepc_q;
      AdrMcause:    reg_rd_data = mcause_q;
      AdrMtval:     reg_rd_data = mtval_q;
      AdrMcycle:    reg_rd_data = mcycle_q[31:0];
      AdrMcycleh:   reg_rd_data = mcycle_q[63:32];
      AdrMinstret:  reg_rd_data = minstret_q[31:0];
      AdrMinstreth: reg_rd_data = minstret_q[63:32];
      AdrMhartid:   reg_rd_data = '0;
      default:      rd_unimpl   = 1'b1;
    endcase
  end

  assign bypass           = csr_wbk_v_q_i && wr_writable && (csr_adr_q_i == csr_rd_adr_i);
  assign csr_rd_data_o    = bypass ? wr_data_m : reg_rd_data;
  assign csr_rd_illegal_o = rd_unimpl;

  // Next state: write first, then trap (or mret) overrides the status/trap fields
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mpp_d      = mpp_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    if (csr_wbk_v_q_i) begin
      if (sel_mstatus) begin
        mie_d  = csr_data_q_i[3];
        mpie_d = csr_data_q_i[7];
        mpp_d  = csr_data_q_i[12:11];
      end
      if (sel_mtvec)    mtvec_d    = wr_data_m;
      if (sel_mscratch) mscratch_d = wr_data_m;
      if (sel_mepc)     mepc_d     = wr_data_m;
      if (sel_mcause)   mcause_d   = wr_data_m;
      if (sel_mtval)    mtval_d    = wr_data_m;
    end

    if (exception_i) begin
      mepc_d   = epc_i & AlignMask;
      mcause_d = cause_i;
      mtval_d  = mtval_i;
      mpie_d   = mie_d;
      mie_d    = 1'b0;
      mpp_d    = 2'b11;
    end else if (mret_i) begin
      mie_d  = mpie_d;
      mpie_d = 1'b1;
      mpp_d  = 2'b00;
    end
  end

  // Counters: a write to either half suppresses that cycle's increment
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (csr_wbk_v_q_i && sel_mcycle) begin
      mcycle_d = {mcycle_q[63:32], csr_data_q_i};
    end else if (csr_wbk_v_q_i && sel_mcycleh) begin
      mcycle_d = {csr_data_q_i, mcycle_q[31:0]};
    end

    minstret_d = minstret_q;
    if (csr_wbk_v_q_i && sel_minstret) begin
      minstret_d = {minstret_q[63:32], csr_data_q_i};
    end else if (csr_wbk_v_q_i && sel_minstreth) begin
      minstret_d = {csr_data_q_i, minstret_q[31:0]};
    end else if (instret_i) begin
      minstret_d = minstret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b11;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mpp_q      <= mpp_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mtvec_q_o       = mtvec_q;
  assign mepc_q_o        = mepc_q;
  assign mstatus_mie_q_o = mie_q;

endmodule
